// File: rtl/cska_pkg.sv
// Shared definitions for the pipelined carry-skip adder/subtractor.
//   n_blocks()    : number of ripple blocks for a given operand width
//   cska_flags_t  : carry-out / signed-overflow pair held in the last stage
//   DEF_*         : default geometry (64-bit operands, 4-bit blocks, 2 stages)
package cska_pkg;

  localparam int DEF_WIDTH  = 64;
  localparam int DEF_BLOCK  = 4;
  localparam int DEF_STAGES = 2;

  typedef struct packed {
    logic cout;
    logic ovf;
  } cska_flags_t;

  function automatic int n_blocks(input int width, input int block);
    return width / block;
  endfunction

endpackage

// File: rtl/cska_block.sv
// One carry-skip block: BLOCK-bit ripple chain plus skip multiplexer.
//   a, b       : block operand slices (b is already inverted for subtract)
//   cin        : carry into the block
//   sum        : block sum bits, always taken from the ripple chain
//   cout_skip  : carry out; bypasses the ripple chain when every bit propagates
//   p          : block propagate (all bit positions a^b)
module cska_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout_skip,
  output logic             p
);

  logic [BLOCK:0]   c;
  logic [BLOCK-1:0] t;

  assign t    = a ^ b;
  assign c[0] = cin;

  for (genvar i = 0; i < BLOCK; i++) begin : g_bit
    assign sum[i]   = t[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (t[i] & c[i]);
  end

  assign p         = &t;
  assign cout_skip = p ? cin : c[BLOCK];

endmodule

// File: rtl/cska_pipe.sv
// Pipelined carry-skip adder/subtractor with valid/ready on both sides.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : input handshake; in_ready depends only on output side
//   in_a, in_b, in_cin    : operands and carry-in (carry-in ignored when subtracting)
//   in_sub                : 1 = A-B
//   out_valid/out_ready   : output handshake
//   out_sum, out_cout,
//   out_ovf               : result, carry out of MSB, signed overflow
// Stage s handles blocks [s*K, (s+1)*K). Each non-final stage registers the
// sum bits finished so far, the operand bits still to be consumed and its
// outgoing carry. The whole pipe advances or holds together.
module cska_pipe
  import cska_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int BLOCK  = DEF_BLOCK,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NB = n_blocks(WIDTH, BLOCK);
  localparam int K  = NB / ((STAGES < 1) ? 1 : STAGES);
  localparam int SW = K * BLOCK;

  if ((WIDTH % BLOCK) != 0 || STAGES < 1 || (NB % ((STAGES < 1) ? 1 : STAGES)) != 0)
  begin : g_bad_cfg
    $error("cska_pipe: WIDTH must be a multiple of BLOCK and WIDTH/BLOCK a multiple of STAGES");
  end

  logic              adv;
  logic [STAGES-1:0] vld_q;
  logic [WIDTH-1:0]  beff_in;
  logic              cin_eff;
  cska_flags_t       flags_q;

  assign adv      = ~vld_q[STAGES-1] | out_ready;
  assign in_ready = adv;
  assign beff_in  = in_sub ? ~in_b : in_b;
  assign cin_eff  = in_sub | in_cin;

  // Bubbles travel with the data; nothing is collapsed.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q[0] <= in_valid;
      for (int s = 1; s < STAGES; s++) vld_q[s] <= vld_q[s-1];
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int DONE = (s + 1) * SW;
    localparam int REM  = WIDTH - DONE;

    logic [SW-1:0]   a_s;
    logic [SW-1:0]   b_s;
    logic [SW-1:0]   sum_s;
    logic [K:0]      c_s;
    logic [K-1:0]    p_s;
    logic            c_out;
    logic [DONE-1:0] sum_nxt;
    logic [DONE-1:0] sum_q;

    if (s == 0) begin : g_src
      assign a_s     = in_a[SW-1:0];
      assign b_s     = beff_in[SW-1:0];
      assign c_s[0]  = cin_eff;
      assign sum_nxt = sum_s;
    end else begin : g_src
      assign a_s     = g_stage[s-1].g_fwd.a_q[SW-1:0];
      assign b_s     = g_stage[s-1].g_fwd.b_q[SW-1:0];
      assign c_s[0]  = g_stage[s-1].g_fwd.c_q;
      assign sum_nxt = {sum_s, g_stage[s-1].sum_q};
    end

    for (genvar k = 0; k < K; k++) begin : g_blk
      cska_block #(.BLOCK(BLOCK)) u_blk (
        .a         (a_s[k*BLOCK +: BLOCK]),
        .b         (b_s[k*BLOCK +: BLOCK]),
        .cin       (c_s[k]),
        .sum       (sum_s[k*BLOCK +: BLOCK]),
        .cout_skip (c_s[k+1]),
        .p         (p_s[k])
      );
    end

    // Second skip level: a stage that propagates end to end hands its
    // incoming carry straight to the boundary register.
    assign c_out = (&p_s) ? c_s[0] : c_s[K];

    always_ff @(posedge clk) begin
      if (rst)      sum_q <= '0;
      else if (adv) sum_q <= sum_nxt;
    end

    if (s < STAGES - 1) begin : g_fwd
      logic [REM-1:0] a_rem;
      logic [REM-1:0] b_rem;
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;
      logic           c_q;

      if (s == 0) begin : g_rem
        assign a_rem = in_a[WIDTH-1:SW];
        assign b_rem = beff_in[WIDTH-1:SW];
      end else begin : g_rem
        assign a_rem = g_stage[s-1].g_fwd.a_q[REM+SW-1:SW];
        assign b_rem = g_stage[s-1].g_fwd.b_q[REM+SW-1:SW];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
          c_q <= 1'b0;
        end else if (adv) begin
          a_q <= a_rem;
          b_q <= b_rem;
          c_q <= c_out;
        end
      end
    end else begin : g_last
      // The operand MSBs live in this stage's slice, so overflow is
      // resolved here rather than carried as separate bits.
      always_ff @(posedge clk) begin
        if (rst) begin
          flags_q <= '0;
        end else if (adv) begin
          flags_q.cout <= c_out;
          flags_q.ovf  <= (a_s[SW-1] == b_s[SW-1]) && (sum_s[SW-1] != a_s[SW-1]);
        end
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_sum   = g_stage[STAGES-1].sum_q;
  assign out_cout  = flags_q.cout;
  assign out_ovf   = flags_q.ovf;

endmodule

// File: tb/tb_cska_pipe.sv
// Bench for cska_pipe: directed cases on the default 64/4/2 geometry and
// random streams with random back-pressure on several other geometries,
// all compared against an arithmetic reference model.
module tb_cska_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Reference: {ovf, cout, sum} for a w-bit add or subtract.
  function automatic logic [65:0] ref_op(input int w, input logic [63:0] a_in,
                                         input logic [63:0] b_in, input logic cin,
                                         input logic sub);
    logic [63:0] mask, a, b, s;
    logic [64:0] f;
    logic        co, bmsb, ov;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a = a_in & mask;
    b = b_in & mask;
    if (sub) begin
      s    = (a - b) & mask;
      co   = (a >= b);
      bmsb = ~b[w-1];
    end else begin
      f    = {1'b0, a} + {1'b0, b} + {64'd0, cin};
      s    = f[63:0] & mask;
      co   = f[w];
      bmsb = b[w-1];
    end
    ov = (a[w-1] == bmsb) && (s[w-1] != a[w-1]);
    return {ov, co, s};
  endfunction

  // ---------------- default-geometry DUT ----------------
  logic        rst, in_valid, in_ready, in_cin, in_sub, out_valid, out_ready, out_cout, out_ovf;
  logic [63:0] in_a, in_b, out_sum;

  cska_pipe #(.WIDTH(64), .BLOCK(4), .STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  // ---------------- sweep DUTs ----------------
  function automatic int cfg_w(input int g);
    return (g == 3) ? 4 : 64;
  endfunction
  function automatic int cfg_b(input int g);
    case (g)
      0:       return 2;
      1:       return 8;
      default: return 4;
    endcase
  endfunction
  function automatic int cfg_s(input int g);
    case (g)
      0:       return 16;
      2:       return 4;
      default: return 1;
    endcase
  endfunction

  localparam int SW_OPS = 250;

  logic rst_sw;
  initial begin
    rst_sw = 1'b1;
    repeat (2) @(negedge clk);
    rst_sw = 1'b0;
  end

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int W = cfg_w(g);
    localparam int B = cfg_b(g);
    localparam int S = cfg_s(g);

    logic         iv, ir, icin, isub, ov, ordy, oc, oo;
    logic [W-1:0] ia, ib, os;
    logic         done = 1'b0;
    logic [65:0]  q[$];

    cska_pipe #(.WIDTH(W), .BLOCK(B), .STAGES(S)) u_sw (
      .clk(clk), .rst(rst_sw), .in_valid(iv), .in_ready(ir),
      .in_a(ia), .in_b(ib), .in_cin(icin), .in_sub(isub),
      .out_valid(ov), .out_ready(ordy),
      .out_sum(os), .out_cout(oc), .out_ovf(oo)
    );

    initial begin
      int           sent, got, sel;
      logic         stall_prev, h_c, h_o;
      logic [W-1:0] h_sum;
      logic [63:0]  x, y;
      logic [65:0]  e;
      sent = 0; got = 0; stall_prev = 1'b0;
      h_sum = '0; h_c = 1'b0; h_o = 1'b0;
      iv = 1'b0; ia = '0; ib = '0; icin = 1'b0; isub = 1'b0; ordy = 1'b0;
      repeat (4) @(negedge clk);
      for (int cyc = 0; cyc < 6000 && (sent < SW_OPS || got < sent); cyc++) begin
        @(negedge clk);
        sel = int'($urandom_range(0, 7));
        x = (sel < 2) ? '1 : rnd64();
        y = (sel == 0) ? '0 : rnd64();
        iv   = (sent < SW_OPS) && ($urandom_range(0, 3) != 0);
        ia   = x[W-1:0];
        ib   = y[W-1:0];
        icin = 1'($urandom_range(0, 1));
        isub = (sel == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        ordy = 1'($urandom_range(0, 1));
        #1;
        if (stall_prev) begin
          chk($sformatf("sw%0d_hold_sum", g), 64'(os), 64'(h_sum));
          chk($sformatf("sw%0d_hold_flg", g), {62'd0, oc, oo}, {62'd0, h_c, h_o});
        end
        if (iv && ir) begin
          q.push_back(ref_op(W, 64'(ia), 64'(ib), icin, isub));
          sent++;
        end
        if (ov && ordy) begin
          chk($sformatf("sw%0d_nonempty", g), 64'(q.size() > 0), 64'd1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk($sformatf("sw%0d_sum", g), 64'(os), e[63:0]);
            chk($sformatf("sw%0d_cout", g), 64'(oc), 64'(e[64]));
            chk($sformatf("sw%0d_ovf", g), 64'(oo), 64'(e[65]));
          end
          got++;
        end
        stall_prev = ov && !ordy;
        h_sum = os; h_c = oc; h_o = oo;
      end
      chk($sformatf("sw%0d_count", g), 64'(got), 64'(SW_OPS));
      done = 1'b1;
    end
  end

  // ---------------- directed tests ----------------
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic sub, input logic [63:0] es,
                        input logic ec, input logic eo);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub; out_ready = 1'b1;
    #1 chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    // Scramble inputs after the transfer: later stages must not look at them.
    in_valid = 1'b0; in_a = rnd64(); in_b = rnd64(); in_sub = ~sub; in_cin = ~cin;
    #1 chk({tag, "_lat"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    #1;
    chk({tag, "_vld"}, 64'(out_valid), 64'd1);
    chk({tag, "_sum"}, out_sum, es);
    chk({tag, "_cout"}, 64'(out_cout), 64'(ec));
    chk({tag, "_ovf"}, 64'(out_ovf), 64'(eo));
  endtask

  initial begin
    logic [65:0] bq[$];
    logic [65:0] e;
    logic [63:0] h_sum;
    logic        h_c, h_o, stall_prev, all_done;
    int          sent, got;

    rst = 1'b1; in_valid = 1'b1; in_a = rnd64(); in_b = rnd64();
    in_cin = 1'b1; in_sub = 1'b0; out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rst_vld", 64'(out_valid), 64'd0);
      chk("rst_sum", out_sum, 64'd0);
    end
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_rdy", 64'(in_ready), 64'd1);
    chk("post_rst_vld", 64'(out_valid), 64'd0);
    chk("post_rst_flg", {62'd0, out_cout, out_ovf}, 64'd0);

    run_op("skip", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
    run_op("sub57", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_op("sub75", 64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0);
    run_op("sub75c", 64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 1'b1, 1'b0);
    run_op("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
           64'h8000_0000_0000_0000, 1'b0, 1'b1);

    // In-flight flush: an accepted op must never appear after reset.
    @(negedge clk);
    in_valid = 1'b1; in_a = 64'd3; in_b = 64'd4; in_sub = 1'b0; in_cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1 chk("flush_vld", 64'(out_valid), 64'd0);
    end

    // Back-pressure: 10 ops, consumer stalls during cycles 3..7.
    sent = 0; got = 0; stall_prev = 1'b0; h_sum = '0; h_c = 1'b0; h_o = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      @(negedge clk);
      in_valid  = (sent < 10);
      in_a      = rnd64();
      in_b      = rnd64();
      in_cin    = 1'b0;
      in_sub    = 1'b0;
      out_ready = !(cyc >= 3 && cyc <= 7);
      #1;
      chk("bp_rdy", 64'(in_ready), 64'(!(cyc >= 3 && cyc <= 7)));
      if (stall_prev) begin
        chk("bp_hold_sum", out_sum, h_sum);
        chk("bp_hold_flg", {62'd0, out_cout, out_ovf}, {62'd0, h_c, h_o});
      end
      if (in_valid && in_ready) begin
        bq.push_back(ref_op(64, in_a, in_b, 1'b0, 1'b0));
        sent++;
      end
      if (out_valid && out_ready) begin
        chk("bp_nonempty", 64'(bq.size() > 0), 64'd1);
        if (bq.size() > 0) begin
          e = bq.pop_front();
          chk("bp_sum", out_sum, e[63:0]);
          chk("bp_cout", 64'(out_cout), 64'(e[64]));
        end
        got++;
      end
      stall_prev = out_valid && !out_ready;
      h_sum = out_sum; h_c = out_cout; h_o = out_ovf;
    end
    chk("bp_count", 64'(got), 64'd10);
    out_ready = 1'b1;

    all_done = 1'b0;
    for (int t = 0; t < 20000 && !all_done; t++) begin
      @(negedge clk);
      all_done = g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done;
    end
    chk("sweep_finished", 64'(all_done), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
